clb_config_loader: RTL and testbench
====================================

Name: clb_config_loader

Overview:
- Sequences configuration loading into NUM_CLB per-CLB 18-bit serial-in/parallel-out configuration registers. The registers share one serial data line; each has its own enable.
- Accepts one parallel frame per CLB from the host over a valid/ready handshake. Serializes each frame LSB first into the selected register, clears the chain before each load, and reports done or timeout.

Parameters:
FRAME_W, 18, bits per CLB configuration frame (shift length per CLB)
NUM_CLB, 4, number of CLB registers loaded per configuration pass (>=1)
IDX_W, 2, width of CLB index; must satisfy 2**IDX_W >= NUM_CLB
TIMEOUT, 255, max cycles spent in WAIT_FRM before the pass aborts with ERR (>=1)

Ports:
WCLOCK  in  1  clock; all state updates on the rising edge
RES  in  1  asynchronous active-high reset
START  in  1  begin a configuration pass; sampled only in IDLE
ABORT  in  1  terminate the current pass; no effect in IDLE
FRM_DATA  in  FRAME_W  configuration frame for the current CLB
FRM_VALID  in  1  FRM_DATA valid
FRM_READY  out  1  loader accepts a frame this cycle
SIPO_DAT  out  1  shared serial data to all CLB registers
SIPO_EN  out  NUM_CLB  one-hot shift enable, bit i drives CLB register i
SIPO_RES  out  1  synchronous clear to all CLB registers
CLB_IDX  out  IDX_W  index of the CLB currently being loaded
BUSY  out  1  pass in progress (any state other than IDLE)
CFG_DONE  out  1  one-cycle pulse: all NUM_CLB frames shifted
ERR  out  1  sticky: last pass ended by timeout; cleared on an accepted START

Behaviour:
- All outputs are registered except FRM_READY, which is 1 exactly when state==WAIT_FRM.
- RES (async, any time, including mid-shift):
  - state=IDLE; SIPO_EN=0, SIPO_DAT=0, CLB_IDX=0, BUSY=0, CFG_DONE=0, ERR=0.
  - SIPO_RES=1, dropping to 0 on the first WCLOCK edge after RES deasserts.
- States: IDLE, CLEAR, WAIT_FRM, SHIFT, DONE.
- IDLE:
  - START=1 -> CLEAR; ERR cleared; BUSY=1 from the next cycle.
  - ABORT is ignored.
- CLEAR:
  - SIPO_RES=1 for exactly one cycle; CLB_IDX=0; wait counter=0; -> WAIT_FRM.
- WAIT_FRM:
  - FRM_VALID=1 -> capture FRM_DATA into the shift register, bit counter=0, -> SHIFT.
  - Otherwise the wait counter increments. When it reaches TIMEOUT with no frame, set ERR=1 and go to IDLE; no CFG_DONE.
- SHIFT, exactly FRAME_W cycles:
  - SIPO_EN=one-hot(CLB_IDX) and SIPO_DAT=frame bit k on the k-th cycle, k=0..FRAME_W-1 (LSB first). After FRAME_W edges, bit 0 lands in register bit 0.
  - SIPO_EN=0 and SIPO_DAT=0 in every other state.
  - After the last bit: if CLB_IDX==NUM_CLB-1 -> DONE; else CLB_IDX+1, wait counter=0, -> WAIT_FRM.
  - No gap cycles inside a frame. One WAIT_FRM cycle minimum between frames.
- DONE: CFG_DONE=1 for one cycle; -> IDLE; CLB_IDX returns to 0.
- ABORT=1 in CLEAR/WAIT_FRM/SHIFT/DONE:
  - Next edge: state=IDLE, SIPO_EN=0, no CFG_DONE, ERR unchanged.
  - A partially shifted register keeps its contents; no clear is issued.
  - ABORT has priority over a same-cycle frame handshake: the frame is not accepted.
- START while BUSY: ignored.
- START and ABORT together in IDLE: START wins.
- FRM_VALID outside WAIT_FRM: ignored; FRM_DATA is not sampled.
- Minimum pass length: 1 + NUM_CLB*(FRAME_W+1) + 1 cycles from START acceptance to CFG_DONE, with FRM_VALID held high.

Test Plan:
- Defaults, FRM_VALID held high, frames 18'h2AAAA, 18'h15555, 18'h3FFFF, 18'h00001 -> SIPO_RES one cycle; SIPO_EN = 0001, 0010, 0100, 1000 for 18 cycles each. Captured registers equal the frames. CFG_DONE pulses on cycle 1+4*19+1=78 after START; ERR=0.
- Frame 18'h00001 for CLB0 -> SIPO_DAT=1 only on the first SHIFT cycle, 0 for the remaining 17. Register 0 reads 18'h00001.
- TIMEOUT=8, START then no FRM_VALID -> FRM_READY high 8 cycles, then ERR=1, BUSY=0, no CFG_DONE. Next START clears ERR.
- ABORT on the 10th SHIFT cycle of CLB1 -> SIPO_EN=0 next cycle, IDLE; CLB1 register holds 10 shifted bits; no CFG_DONE.
- RES asserted mid-SHIFT (asynchronous, between edges) -> SIPO_EN=0 and SIPO_RES=1 immediately. After release, IDLE with all outputs 0.
- START pulsed again while BUSY, plus FRM_VALID during SHIFT -> no restart and no extra frame accepted; pass completes with 4 frames.

Source files
------------

// File: rtl/clb_config_loader.sv
// clb_config_loader: loads one parallel frame per CLB into per-CLB serial-in/parallel-out config registers
// Ports:
//   WCLOCK, RES         clock, asynchronous active-high reset
//   START, ABORT        begin a pass (IDLE only) / terminate a pass (ignored in IDLE)
//   FRM_DATA/VALID/READY frame handshake; READY is high exactly in WAIT_FRM
//   SIPO_DAT, SIPO_EN   shared serial data (LSB first) and one-hot per-CLB shift enable
//   SIPO_RES            synchronous clear to every CLB register
//   CLB_IDX, BUSY       CLB currently loaded, pass in progress
//   CFG_DONE, ERR       one-cycle completion pulse, sticky timeout flag
module clb_config_loader #(
    parameter int FRAME_W = 18,
    parameter int NUM_CLB = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic               WCLOCK,
    input  logic               RES,
    input  logic               START,
    input  logic               ABORT,
    input  logic [FRAME_W-1:0] FRM_DATA,
    input  logic               FRM_VALID,
    output logic               FRM_READY,
    output logic               SIPO_DAT,
    output logic [NUM_CLB-1:0] SIPO_EN,
    output logic               SIPO_RES,
    output logic [IDX_W-1:0]   CLB_IDX,
    output logic               BUSY,
    output logic               CFG_DONE,
    output logic               ERR
);
    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam int BC_W = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_FRM, SHIFT, DONE} state_t;

    state_t             state_q;
    logic [FRAME_W-1:0] frame_q;
    logic [BC_W-1:0]    bcnt_q;
    logic [WC_W-1:0]    wcnt_q;

    assign FRM_READY = (state_q == WAIT_FRM);

    // frame_q holds the bits not yet presented; SIPO_DAT is loaded one cycle
    // ahead so the registered output shows bit k during the k-th SHIFT cycle
    always_ff @(posedge WCLOCK or posedge RES) begin
        if (RES) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            bcnt_q   <= '0;
            wcnt_q   <= '0;
            SIPO_EN  <= '0;
            SIPO_DAT <= 1'b0;
            SIPO_RES <= 1'b1;
            CLB_IDX  <= '0;
            BUSY     <= 1'b0;
            CFG_DONE <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            SIPO_RES <= 1'b0;
            CFG_DONE <= 1'b0;
            if (state_q != IDLE && ABORT) begin
                state_q  <= IDLE;
                SIPO_EN  <= '0;
                SIPO_DAT <= 1'b0;
                CLB_IDX  <= '0;
                BUSY     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (START) begin
                        state_q  <= CLEAR;
                        ERR      <= 1'b0;
                        BUSY     <= 1'b1;
                        SIPO_RES <= 1'b1;
                    end
                    CLEAR: begin
                        state_q <= WAIT_FRM;
                        CLB_IDX <= '0;
                        wcnt_q  <= '0;
                    end
                    WAIT_FRM: if (FRM_VALID) begin
                        state_q  <= SHIFT;
                        frame_q  <= FRM_DATA >> 1;
                        SIPO_DAT <= FRM_DATA[0];
                        SIPO_EN  <= NUM_CLB'(1) << CLB_IDX;
                        bcnt_q   <= '0;
                    end else if (wcnt_q == WC_W'(TIMEOUT - 1)) begin
                        state_q <= IDLE;
                        ERR     <= 1'b1;
                        BUSY    <= 1'b0;
                        CLB_IDX <= '0;
                    end else begin
                        wcnt_q <= wcnt_q + WC_W'(1);
                    end
                    SHIFT: if (bcnt_q == BC_W'(FRAME_W - 1)) begin
                        SIPO_EN  <= '0;
                        SIPO_DAT <= 1'b0;
                        if (CLB_IDX == IDX_W'(NUM_CLB - 1)) begin
                            state_q  <= DONE;
                            CFG_DONE <= 1'b1;
                        end else begin
                            state_q <= WAIT_FRM;
                            CLB_IDX <= CLB_IDX + IDX_W'(1);
                            wcnt_q  <= '0;
                        end
                    end else begin
                        bcnt_q   <= bcnt_q + BC_W'(1);
                        SIPO_DAT <= frame_q[0];
                        frame_q  <= frame_q >> 1;
                    end
                    DONE: begin
                        state_q <= IDLE;
                        BUSY    <= 1'b0;
                        CLB_IDX <= '0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_clb_config_loader.sv
// tb_clb_config_loader: self-checking bench for clb_config_loader
module tb_clb_config_loader;
    localparam int FW = 18;
    localparam int NC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, abort, valid;
    logic [FW-1:0] data;
    logic          ready, sdat, sres, busy, done, err;
    logic [NC-1:0] sen;
    logic [1:0]    idx;

    logic          start2, abort2, valid2;
    logic [FW-1:0] data2;
    logic          ready2, sdat2, sres2, busy2, done2, err2;
    logic [NC-1:0] sen2;
    logic [1:0]    idx2;

    clb_config_loader dut (
        .WCLOCK(clk), .RES(rst), .START(start), .ABORT(abort),
        .FRM_DATA(data), .FRM_VALID(valid), .FRM_READY(ready),
        .SIPO_DAT(sdat), .SIPO_EN(sen), .SIPO_RES(sres), .CLB_IDX(idx),
        .BUSY(busy), .CFG_DONE(done), .ERR(err)
    );

    clb_config_loader #(.TIMEOUT(8)) dut2 (
        .WCLOCK(clk), .RES(rst), .START(start2), .ABORT(abort2),
        .FRM_DATA(data2), .FRM_VALID(valid2), .FRM_READY(ready2),
        .SIPO_DAT(sdat2), .SIPO_EN(sen2), .SIPO_RES(sres2), .CLB_IDX(idx2),
        .BUSY(busy2), .CFG_DONE(done2), .ERR(err2)
    );

    // the CLB configuration registers themselves: serial in at the MSB, so
    // after FRAME_W shifts the first bit sent sits in bit 0
    logic [FW-1:0] regs [NC];
    always @(posedge clk) begin
        for (int i = 0; i < NC; i++)
            if (sres) regs[i] <= '0;
            else if (sen[i]) regs[i] <= {sdat, regs[i][FW-1:1]};
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One pass: hold keeps FRM_VALID high throughout; otherwise random WAIT gaps
    // (up to maxgap), junk FRM_VALID/START outside WAIT_FRM. abort_at>=0 raises
    // ABORT on that global SHIFT cycle. Expected timing and contents come from
    // the frames and the gaps alone.
    task automatic do_pass(input logic [FW-1:0] f [NC], input bit hold, input int maxgap,
                           input int abort_at, input bit start_abort);
        int cyc, bits, k, gap, gaps_total, res_cnt, ndone, n;
        bit fin, ab_sent;
        logic [FW-1:0] e;
        @(negedge clk);
        start = 1'b1; abort = start_abort; valid = hold; data = FW'($urandom);
        cyc = 0; bits = 0; k = 0; gaps_total = 0; res_cnt = 0; ndone = 0;
        fin = 0; ab_sent = 0;
        gap = hold ? 0 : int'($urandom_range(maxgap));
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("busy_after_start", busy, 1);
                chk("err_cleared", err, 0);
                chk("idx_clear", idx, 0);
            end
            if (ab_sent) begin
                chk("abort_en", sen, 0);
                chk("abort_busy", busy, 0);
                chk("abort_ready", ready, 0);
                fin = 1;
            end
            if (sres) res_cnt++;
            if (sen != 0) begin
                if (bits < NC * FW) begin
                    chk("sipo_en", sen, 32'(1) << (bits / FW));
                    chk("sipo_dat", sdat, f[bits / FW][bits % FW]);
                end else chk("extra_shift", bits, NC * FW - 1);
                bits++;
            end else chk("sipo_dat_idle", sdat, 0);
            if (done) begin
                ndone++;
                fin = 1;
                chk("done_cycle", cyc, 2 + NC * (FW + 1) + gaps_total);
            end
            abort = (abort_at >= 0 && !ab_sent && sen != 0 && bits == abort_at);
            if (abort) ab_sent = 1;
            start = (!hold && !fin && !abort) ? 1'($urandom_range(1)) : 1'b0;
            if (ready) begin
                if (gap == 0 && k < NC) begin
                    valid = 1'b1; data = f[k]; k++;
                    gap = hold ? 0 : int'($urandom_range(maxgap));
                end else begin
                    valid = 1'b0; data = FW'($urandom); gap--; gaps_total++;
                end
            end else begin
                valid = hold ? 1'b1 : 1'($urandom_range(1));
                data = FW'($urandom);
            end
        end
        if (!fin) chk("pass_bound", cyc, 0);
        start = 1'b0; abort = 1'b0; valid = 1'b0;
        chk("done_pulses", ndone, abort_at < 0 ? 1 : 0);
        chk("clear_cycles", res_cnt, 1);
        chk("bits_shifted", bits, abort_at < 0 ? NC * FW : abort_at);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_err", err, 0);
        chk("idle_idx", idx, 0);
        chk("idle_done", done, 0);
        for (int i = 0; i < NC; i++) begin
            n = bits - FW * i;
            n = n < 0 ? 0 : (n > FW ? FW : n);
            e = FW'(f[i] << (FW - n));
            chk($sformatf("reg%0d", i), regs[i], e);
        end
    endtask

    initial begin
        logic [FW-1:0] fr [NC];
        int cnt, rdy;
        rst = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0; data = '0;
        start2 = 1'b0; abort2 = 1'b0; valid2 = 1'b0; data2 = '0;
        #1 rst = 1'b1;
        #10;
        chk("rst_sres", sres, 1);
        chk("rst_en", sen, 0);
        chk("rst_dat", sdat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", idx, 0);
        chk("rst_ready", ready, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("sres_release", sres, 0);
        chk("idle_ready", ready, 0);

        fr = '{18'h2AAAA, 18'h15555, 18'h3FFFF, 18'h00001};
        do_pass(fr, 1, 0, -1, 0);
        fr = '{18'h00001, 18'h3FFFF, 18'h00000, 18'h20000};
        do_pass(fr, 1, 0, -1, 0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < NC; i++) fr[i] = FW'($urandom);
            do_pass(fr, 0, 4, -1, p == 1);
        end
        for (int i = 0; i < NC; i++) fr[i] = FW'($urandom);
        do_pass(fr, 1, 0, FW + 10, 0);
        for (int i = 0; i < NC; i++) fr[i] = FW'($urandom);
        do_pass(fr, 0, 3, -1, 0);

        // asynchronous reset between edges in the middle of a shift
        @(negedge clk);
        start = 1'b1; valid = 1'b1; data = FW'($urandom);
        @(negedge clk) start = 1'b0;
        cnt = 0;
        while (sen == 0 && cnt < 50) begin @(negedge clk); cnt++; end
        chk("reach_shift", sen != 0, 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_en", sen, 0);
        chk("async_sres", sres, 1);
        chk("async_busy", busy, 0);
        valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("post_rst_sres", sres, 0);
        chk("post_rst_out", {sen, sdat, idx, busy, done, err, ready}, 0);

        // timeout on the TIMEOUT=8 instance
        chk("to_err_init", err2, 0);
        @(negedge clk) start2 = 1'b1;
        rdy = 0; cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (ready2) rdy++;
            if (done2) cnt++;
        end
        chk("to_ready_cycles", rdy, 8);
        chk("to_no_done", cnt, 0);
        chk("to_err", err2, 1);
        chk("to_busy", busy2, 0);
        chk("to_quiet", {sen2, sdat2, sres2, idx2}, 0);
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        chk("to_err_cleared", err2, 0);
        chk("to_busy_again", busy2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
